// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch
//  Description : Instruction fetch stage. Owns the program counter, issues
//                one instruction-memory request at a time and presents the
//                fetched word to decode, holding it while decode stalls.
//                A redirect (PCSrc) reloads the pc and squashes any fetch
//                in progress, including a response still in flight.
//
//  Ports:
//    clk, rst          clock (rising edge), asynchronous active-high reset
//    PCSrc, PCTarget   redirect pulse and its target address
//    stall             decode cannot accept the presented instruction
//    imem_req_valid/ready, imem_addr      request channel
//    imem_resp_valid, imem_resp_data      response channel
//    instr_valid, Instr, PC_F, PCPlus4_F  registered outputs to decode
//    flush             combinational copy of PCSrc
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'hBFC00000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCSrc,
    input  logic [WIDTH-1:0] PCTarget,
    input  logic             stall,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    output logic             instr_valid,
    output logic [31:0]      Instr,
    output logic [WIDTH-1:0] PC_F,
    output logic [WIDTH-1:0] PCPlus4_F,
    output logic             flush
);

    localparam logic [1:0] c_st_req  = 2'd0;  // ready to issue a request
    localparam logic [1:0] c_st_wait = 2'd1;  // one request outstanding
    localparam logic [1:0] c_st_hold = 2'd2;  // instruction presented to decode

    localparam logic [WIDTH-1:0] c_pc_step    = WIDTH'(4);
    localparam logic [WIDTH-1:0] c_align_mask = ~WIDTH'(3);
    localparam logic [31:0]      c_nop        = 32'h00000013;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_drop;          // outstanding response belongs to a squashed fetch
    logic             r_instr_valid;
    logic [31:0]      r_instr;
    logic [WIDTH-1:0] r_pc_f;
    logic [WIDTH-1:0] r_pc_plus4_f;

    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_pc_seq;
    logic             w_req_fire;

    // Targets are word aligned; the low two bits are simply cleared.
    assign w_target   = PCTarget & c_align_mask;
    assign w_pc_seq   = r_pc + c_pc_step;   // wraps modulo 2^WIDTH

    // A redirect cycle never issues a request: the pc is about to change.
    assign imem_req_valid = (r_state == c_st_req) && !PCSrc;
    assign imem_addr      = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    assign flush       = PCSrc;
    assign instr_valid = r_instr_valid;
    assign Instr       = r_instr;
    assign PC_F        = r_pc_f;
    assign PCPlus4_F   = r_pc_plus4_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_req;
            r_pc          <= RESET_PC;
            r_drop        <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= c_nop;
            r_pc_f        <= RESET_PC;
            r_pc_plus4_f  <= RESET_PC + c_pc_step;
        end else if (PCSrc) begin
            // Redirect wins over stall and over a same-cycle response.
            r_pc          <= w_target;
            r_instr_valid <= 1'b0;
            case (r_state)
                c_st_wait: begin
                    if (imem_resp_valid) begin
                        // The in-flight response landed now: throw it away.
                        r_state <= c_st_req;
                        r_drop  <= 1'b0;
                    end else begin
                        // Response still to come; remember to discard it.
                        r_drop <= 1'b1;
                    end
                end
                default: r_state <= c_st_req;
            endcase
        end else begin
            case (r_state)
                c_st_req: begin
                    if (w_req_fire) begin
                        r_state <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (imem_resp_valid) begin
                        if (r_drop) begin
                            r_drop  <= 1'b0;
                            r_state <= c_st_req;
                        end else begin
                            r_instr       <= imem_resp_data;
                            r_pc_f        <= r_pc;
                            r_pc_plus4_f  <= w_pc_seq;
                            r_instr_valid <= 1'b1;
                            r_state       <= c_st_hold;
                        end
                    end
                end
                c_st_hold: begin
                    // Decode takes the instruction on the first unstalled edge.
                    if (!stall) begin
                        r_pc          <= w_pc_seq;
                        r_instr_valid <= 1'b0;
                        r_state       <= c_st_req;
                    end
                end
                default: r_state <= c_st_req;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch
//  Description : Self-checking bench for pc_fetch. A small memory responder
//                answers requests with an address-derived word; a fetch-slot
//                model predicts every output each cycle. Directed scenarios
//                pin literal values, then a randomized run exercises
//                redirects, stalls, backpressure and response latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch;

    localparam logic [31:0] c_reset_pc = 32'hBFC00000;
    localparam logic [31:0] c_nop      = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [31:0] PC_F;
    logic [31:0] PCPlus4_F;
    logic        flush;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // memory responder state
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_lat  = 0;
    int          lat_cfg  = 0;      // <0 selects a random latency

    // fetch-slot model
    logic [31:0] m_pc;
    bit          m_out;             // a request is in flight
    bit          m_discard;         // the in-flight response must be thrown away
    bit          m_have;            // an instruction is presented to decode
    logic [31:0] m_instr;
    logic [31:0] m_pcf;

    pc_fetch #(.WIDTH(32), .RESET_PC(32'hBFC00000)) dut (
        .clk             (clk),
        .rst             (rst),
        .PCSrc           (PCSrc),
        .PCTarget        (PCTarget),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .Instr           (Instr),
        .PC_F            (PC_F),
        .PCPlus4_F       (PCPlus4_F),
        .flush           (flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC00000) return 32'h00500093;
        return {a[7:0], a[31:8]} ^ 32'h6A09E667;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: one outstanding request, response after mem_lat idle cycles.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                if (mem_pend) begin
                    if (imem_resp_valid) mem_pend = 1'b0;
                    else if (mem_lat > 0) mem_lat--;
                end
                if (imem_req_valid && imem_req_ready) begin
                    mem_pend = 1'b1;
                    mem_addr = imem_addr;
                    mem_lat  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
                end
            end
        end
    end

    // Fetch-slot model: what the fetch stage holds after each edge.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_pc = c_reset_pc; m_out = 0; m_discard = 0; m_have = 0;
                m_instr = c_nop; m_pcf = c_reset_pc;
            end else if (PCSrc) begin
                m_pc   = PCTarget & ~32'h3;
                m_have = 0;
                if (m_out) begin
                    if (imem_resp_valid) begin m_out = 0; m_discard = 0; end
                    else m_discard = 1;
                end
            end else if (m_out) begin
                if (imem_resp_valid) begin
                    m_out = 0;
                    if (m_discard) m_discard = 0;
                    else begin m_have = 1; m_instr = imem_resp_data; m_pcf = m_pc; end
                end
            end else if (m_have) begin
                if (!stall) begin m_have = 0; m_pc = m_pc + 32'd4; end
            end else if (imem_req_ready) begin
                m_out = 1;
            end
        end
    end

    // Compare process: every cycle, after inputs have settled.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (cmp_en) begin
                chk("req_valid",   {31'b0, imem_req_valid}, {31'b0, (!m_out && !m_have && !PCSrc)});
                chk("imem_addr",   imem_addr, m_pc);
                chk("flush",       {31'b0, flush}, {31'b0, PCSrc});
                chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
                chk("Instr",       Instr, m_instr);
                chk("PC_F",        PC_F, m_pcf);
                chk("PCPlus4_F",   PCPlus4_F, m_pcf + 32'd4);
            end
        end
    end

    task automatic step(input logic pcsrc, input logic [31:0] tgt, input logic stl, input logic rdy);
        @(negedge clk);
        PCSrc           = pcsrc;
        PCTarget        = tgt;
        stall           = stl;
        imem_req_ready  = rdy;
        imem_resp_valid = mem_pend && (mem_lat == 0);
        imem_resp_data  = imem_resp_valid ? mem_word(mem_addr) : $urandom;
        #2;
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] tgt;
        rst = 1'b1; PCSrc = 0; PCTarget = '0; stall = 0;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        #2;
        chk("rst instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst Instr", Instr, 32'h00000013);
        chk("rst PC_F", PC_F, 32'hBFC00000);
        chk("rst imem_addr", imem_addr, 32'hBFC00000);

        // First fetch with one-cycle response latency.
        lat_cfg = 0;
        step(0, '0, 0, 1);
        chk("fetch0 req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("fetch0 addr", imem_addr, 32'hBFC00000);
        step(0, '0, 1, 0);                       // response lands this cycle
        chk("fetch0 resp", {31'b0, imem_resp_valid}, 32'd1);
        step(0, '0, 1, 0);
        chk("fetch0 instr_valid", {31'b0, instr_valid}, 32'd1);
        chk("fetch0 Instr", Instr, 32'h00500093);
        chk("fetch0 PC_F", PC_F, 32'hBFC00000);
        chk("fetch0 PCPlus4_F", PCPlus4_F, 32'hBFC00004);
        held = Instr;
        // Stall for four cycles in total; outputs must not move.
        for (int i = 0; i < 3; i++) begin
            step(0, '0, 1, 1);
            chk("stall Instr", Instr, held);
            chk("stall valid", {31'b0, instr_valid}, 32'd1);
            chk("stall no req", {31'b0, imem_req_valid}, 32'd0);
        end
        step(0, '0, 0, 0);                       // consumed on this edge
        chk("release valid", {31'b0, instr_valid}, 32'd1);
        step(0, '0, 0, 0);
        chk("next req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("next addr", imem_addr, 32'hBFC00004);
        chk("next instr_valid", {31'b0, instr_valid}, 32'd0);

        // Redirect while waiting; late response is dropped.
        lat_cfg = 2;
        step(0, '0, 0, 1);                       // accepted
        step(1, 32'hBFC00102, 0, 0);
        chk("redir flush", {31'b0, flush}, 32'd1);
        chk("redir no req", {31'b0, imem_req_valid}, 32'd0);
        step(0, '0, 0, 0);
        chk("drop wait addr", imem_addr, 32'hBFC00100);
        step(0, '0, 0, 0);
        chk("drop resp", {31'b0, imem_resp_valid}, 32'd1);
        chk("drop instr_valid", {31'b0, instr_valid}, 32'd0);
        step(0, '0, 0, 0);
        chk("drop after valid", {31'b0, instr_valid}, 32'd0);
        chk("drop next req", {31'b0, imem_req_valid}, 32'd1);
        chk("drop next addr", imem_addr, 32'hBFC00100);

        // Redirect in the same cycle as the response.
        lat_cfg = 0;
        step(0, '0, 0, 1);
        step(1, 32'h00001000, 0, 0);
        chk("same resp", {31'b0, imem_resp_valid}, 32'd1);
        step(0, '0, 0, 0);
        chk("same instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("same next addr", imem_addr, 32'h00001000);
        chk("same next req", {31'b0, imem_req_valid}, 32'd1);

        // Wrap at the top of the address space.
        step(1, 32'hFFFFFFFC, 0, 0);
        step(0, '0, 0, 1);
        chk("wrap addr", imem_addr, 32'hFFFFFFFC);
        step(0, '0, 0, 0);
        step(0, '0, 0, 0);
        chk("wrap PC_F", PC_F, 32'hFFFFFFFC);
        chk("wrap PCPlus4_F", PCPlus4_F, 32'h00000000);
        step(0, '0, 0, 0);
        chk("wrap next addr", imem_addr, 32'h00000000);

        // Reset during a wait; the stale response must not surface.
        lat_cfg = 2;
        step(0, '0, 0, 1);
        step(0, '0, 0, 0);
        #1 rst = 1'b1;
        #1;
        chk("arst instr_valid", {31'b0, instr_valid}, 32'd0);
        chk("arst PC_F", PC_F, 32'hBFC00000);
        chk("arst imem_addr", imem_addr, 32'hBFC00000);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6 && mem_pend; i++) begin
            step(0, '0, 0, 0);
            chk("stale instr_valid", {31'b0, instr_valid}, 32'd0);
        end
        chk("stale drained", {31'b0, mem_pend}, 32'd0);
        step(0, '0, 0, 0);
        chk("stale Instr", Instr, 32'h00000013);
        chk("post rst addr", imem_addr, 32'hBFC00000);
        chk("post rst req", {31'b0, imem_req_valid}, 32'd1);

        // Randomized run.
        lat_cfg = -1;
        for (int i = 0; i < 3000; i++) begin
            tgt = $urandom;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFFFFF0 | ($urandom & 32'hF);
            step(($urandom_range(0, 11) == 0), tgt, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) != 0));
        end

        step(0, '0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
